pipe_elastic: RTL



---
 rtl/pipe_elastic.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_elastic.sv
// rtl/pipe_elastic.sv - elastic LATENCY-stage pipeline with valid/ready, bubble collapse, flush and occupancy
module pipe_elastic #(
   parameter int LATENCY    = 4,
   parameter int WIDTH      = 16,
   parameter bit RESET_DATA = 1'b1
) (
   input  logic                           clk_in,
   input  logic                           rst_n_in,
   input  logic [WIDTH-1:0]               data_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   output logic [WIDTH-1:0]               data_out,
   output logic                           valid_out,
   input  logic                           ready_in,
   input  logic                           flush_in,
   output logic [$clog2(LATENCY+1)-1:0]   count_out
);

   localparam int CW = $clog2(LATENCY + 1);

   if (LATENCY < 1) begin : g_bad_latency
      $error("pipe_elastic: LATENCY must be at least 1");
   end

   logic [LATENCY-1:0] v_q;
   logic [LATENCY-1:0] v_d;
   logic [LATENCY-1:0] adv;
   logic [WIDTH-1:0]   d_q [LATENCY];
   logic [WIDTH-1:0]   d_d [LATENCY];
   logic [CW-1:0]      count_q;
   logic [CW-1:0]      count_d;

   // A stage may move when it is empty or everything downstream of it moves.
   always_comb begin
      adv = '0;
      adv[LATENCY-1] = !v_q[LATENCY-1] | ready_in;
      for (int i = LATENCY - 2; i >= 0; i--) begin
         adv[i] = !v_q[i] | adv[i+1];
      end
   end

   assign ready_out = adv[0] & !flush_in;

   always_comb begin
      v_d = v_q;
      for (int i = 0; i < LATENCY; i++) begin
         d_d[i] = d_q[i];
      end
      if (adv[0]) begin
         v_d[0] = valid_in & ready_out;
         d_d[0] = data_in;
      end
      for (int i = 1; i < LATENCY; i++) begin
         if (adv[i]) begin
            v_d[i] = v_q[i-1];
            d_d[i] = d_q[i-1];
         end
      end
      if (flush_in) begin
         v_d = '0;
      end
      count_d = '0;
      for (int i = 0; i < LATENCY; i++) begin
         count_d = count_d + CW'(v_d[i]);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         v_q     <= '0;
         count_q <= '0;
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
      end
   end

   if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk_in or negedge rst_n_in) begin
         if (!rst_n_in) begin
            for (int i = 0; i < LATENCY; i++) begin
               d_q[i] <= '0;
            end
         end else begin
            d_q <= d_d;
         end
      end
   end else begin : g_data_norst
      always_ff @(posedge clk_in) begin
         d_q <= d_d;
      end
   end

   assign valid_out = v_q[LATENCY-1];
   assign data_out  = d_q[LATENCY-1];
   assign count_out = count_q;

endmodule
